// File: rtl/infernet_net_pkg.sv
// Shared types for the InferNet reply path.
//   tx_request_t : one reply request {recipient IP, recipient MAC, message}.
//                  Bit 0 of each field is the MSB of its first wire byte.
//   tx_state_t   : states of the request-issue FSM in ip_tx_request_queue.
package infernet_net_pkg;

  localparam int unsigned IP_ADDR_WIDTH    = 32;
  localparam int unsigned MAC_ADDR_WIDTH   = 48;
  localparam int unsigned ACCEL_DATA_WIDTH = 10;

  typedef struct packed {
    logic [0:IP_ADDR_WIDTH-1]    ip;
    logic [0:MAC_ADDR_WIDTH-1]   mac;
    logic [0:ACCEL_DATA_WIDTH-1] msg;
  } tx_request_t;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_WAIT_ACK,
    TX_BUSY
  } tx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a registered head output.
//   clk, rst    : clock, synchronous active-high reset
//   push, din   : write request and data (ignored while full)
//   pop         : retire the head entry (ignored while empty)
//   full, empty : derived from the pointers, so they change one cycle after push/pop
//   count       : entries held
//   head        : registered copy of the entry at the read pointer ('0 while empty)
//   head_valid  : head holds a live entry; low for the cycle after a pop while it reloads
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic [WIDTH-1:0]         head,
  output logic                     head_valid
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Extra pointer MSB distinguishes full from empty when the low bits match.
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign count   = wr_ptr - rd_ptr;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr[AW-1:0]] <= din;
    end
  end

  // The slot under rd_ptr is never rewritten while non-empty, so head stays
  // frozen until the pop moves rd_ptr.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      head       <= '0;
      head_valid <= 1'b0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      head       <= empty ? '0 : mem[rd_ptr[AW-1:0]];
      head_valid <= !empty && !do_pop;
    end
  end

endmodule

// File: rtl/ip_tx_request_queue.sv
// Request queue in front of ip_packet_tx.
// Buffers {IP, MAC, message} reply requests and issues them one at a time,
// holding the head fields stable for the whole frame.
//   ACLK, ARESET           : clock, synchronous active-high reset
//   REQ_*                  : request input, accepted when REQ_VALID && REQ_READY
//   REQ_READY              : !full (registered pointers, no path from pop)
//   RECIPIENT_*            : registered head entry fields to the transmitter
//   START_IP_TXN           : one-cycle frame start pulse
//   READY_FOR_SEND         : transmitter idle
//   OCCUPANCY              : entries held, including the one in flight
//   TIMEOUT_ERR            : sticky; a START was never acknowledged
module ip_tx_request_queue #(
  parameter int unsigned DEPTH          = 4,
  parameter int unsigned IP_ADDR_WIDTH  = 32,
  parameter int unsigned MAC_ADDR_WIDTH = 48,
  parameter int unsigned MSG_WIDTH      = 10,
  parameter int unsigned ACK_TIMEOUT    = 8
) (
  input  logic                      ACLK,
  input  logic                      ARESET,
  input  logic [0:IP_ADDR_WIDTH-1]  REQ_IP_ADDRESS,
  input  logic [0:MAC_ADDR_WIDTH-1] REQ_MAC_ADDRESS,
  input  logic [0:MSG_WIDTH-1]      REQ_MESSAGE,
  input  logic                      REQ_VALID,
  output logic                      REQ_READY,
  output logic [0:IP_ADDR_WIDTH-1]  RECIPIENT_IP_ADDRESS,
  output logic [0:MAC_ADDR_WIDTH-1] RECIPIENT_MAC_ADDRESS,
  output logic [0:MSG_WIDTH-1]      RECIPIENT_MESSAGE,
  output logic                      START_IP_TXN,
  input  logic                      READY_FOR_SEND,
  output logic [$clog2(DEPTH):0]    OCCUPANCY,
  output logic                      TIMEOUT_ERR
);

  import infernet_net_pkg::*;

  localparam int unsigned CNT_W = $clog2(ACK_TIMEOUT + 1);

  tx_request_t      req_entry;
  tx_request_t      head_entry;
  logic             fifo_full;
  logic             fifo_empty;
  logic             head_valid;
  logic             pop;
  logic             ack_expired;
  tx_state_t        state;
  logic [CNT_W-1:0] ack_cnt;

  assign req_entry = '{ip: REQ_IP_ADDRESS, mac: REQ_MAC_ADDRESS, msg: REQ_MESSAGE};

  sync_fifo #(
    .WIDTH ($bits(tx_request_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (ACLK),
    .rst        (ARESET),
    .push       (REQ_VALID),
    .pop        (pop),
    .din        (req_entry),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .count      (OCCUPANCY),
    .head       (head_entry),
    .head_valid (head_valid)
  );

  assign REQ_READY             = !fifo_full;
  assign RECIPIENT_IP_ADDRESS  = head_entry.ip;
  assign RECIPIENT_MAC_ADDRESS = head_entry.mac;
  assign RECIPIENT_MESSAGE     = head_entry.msg;

  assign ack_expired = (ack_cnt == CNT_W'(ACK_TIMEOUT - 1));

  // Pop on the same conditions that return the FSM to IDLE.
  always_comb begin
    pop = 1'b0;
    unique case (state)
      TX_WAIT_ACK: pop = READY_FOR_SEND && ack_expired;
      TX_BUSY:     pop = READY_FOR_SEND;
      default:     pop = 1'b0;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state        <= TX_IDLE;
      START_IP_TXN <= 1'b0;
      ack_cnt      <= '0;
      TIMEOUT_ERR  <= 1'b0;
    end else begin
      START_IP_TXN <= 1'b0;
      unique case (state)
        TX_IDLE: begin
          // head_valid gates out the cycle right after a pop, giving one idle
          // cycle between frames while the head register reloads.
          if (head_valid && !fifo_empty && READY_FOR_SEND) begin
            START_IP_TXN <= 1'b1;
            ack_cnt      <= '0;
            state        <= TX_WAIT_ACK;
          end
        end
        TX_WAIT_ACK: begin
          if (!READY_FOR_SEND) begin
            state <= TX_BUSY;
          end else if (ack_expired) begin
            TIMEOUT_ERR <= 1'b1;
            state       <= TX_IDLE;
          end else begin
            ack_cnt <= ack_cnt + 1'b1;
          end
        end
        TX_BUSY: begin
          if (READY_FOR_SEND) begin
            state <= TX_IDLE;
          end
        end
        default: state <= TX_IDLE;
      endcase
    end
  end

endmodule
